mem_port_arbiter: RTL and testbench
===================================

// Module: mem_port_arbiter
// PURPOSE
// - Shares one memory bus port between instruction fetch (I) and the MEM-stage/atomic-unit data path (D).
// - Serialises their requests and holds the grant on D across atomic read-modify-write sequences (d_lock).
// - Returns per-port acks, and stall flags for the pipeline controller.
// PARAMETERS
// - ADDR_W          32   address width
// - DATA_W          32   data width (byte enables = DATA_W/8)
// - STARVE_LIMIT    4    consecutive D grants with I waiting before I is forced next (1..15)
// - TIMEOUT_CYCLES  256  watchdog limit in cycles; used only with MEM_ARB_TIMEOUT_EN
// PORTS
// - clk       in   1         clock, all state on rising edge
// - reset     in   1         synchronous, active-high
// - i_req     in   1         fetch request; held with i_addr until i_ack
// - i_addr    in   ADDR_W    fetch address
// - i_ack     out  1         one-cycle completion pulse to fetch
// - i_rdata   out  DATA_W    fetch read data, valid with i_ack
// - d_req     in   1         data request; held with payload until d_ack
// - d_we      in   1         1 = write
// - d_addr    in   ADDR_W    data address
// - d_wdata   in   DATA_W    write data
// - d_be      in   DATA_W/8  byte enables
// - d_lock    in   1         atomic lock: keep bus on D after this transaction
// - d_ack     out  1         one-cycle completion pulse to data side
// - d_rdata   out  DATA_W    data read data, valid with d_ack
// - m_req     out  1         bus request; held until m_ack
// - m_we, m_addr, m_wdata, m_be  out  1/ADDR_W/DATA_W/DATA_W/8  registered bus payload
// - m_ack     in   1         bus completion pulse
// - m_rdata   in   DATA_W    bus read data, valid with m_ack
// - stall_if  out  1         i_req & ~i_ack (combinational)
// - stall_mem out  1         d_req & ~d_ack (combinational)
// - bus_err   out  1         timeout pulse, coincident with the aborted ack (0 without macro)
// BEHAVIOUR
// - States: IDLE, BUSY_I, BUSY_D, LOCK_HOLD. On reset: IDLE, m_req=0, all m_* payload=0,
//   starve_cnt=0, acks=0, bus_err=0.
// - IDLE, I only: latch I payload (m_we=0, m_be=all 1s) -> BUSY_I.
// - IDLE, D only: latch D payload -> BUSY_D.
// - IDLE, both requesting: D wins unless starve_cnt==STARVE_LIMIT, in which case I wins.
// - Starve counter: increments on each D grant while i_req=1; clears on any I grant.
// - BUSY_x: m_req=1 with payload stable. On m_ack: x_ack=1, x_rdata=m_rdata, m_req drops in the same cycle.
//   - BUSY_I -> IDLE.
//   - BUSY_D -> LOCK_HOLD if d_lock=1 in the ack cycle, else IDLE.
// - Non-granted port: ack=0, rdata=0.
// - LOCK_HOLD: i_req ignored, including at the starve limit.
//   - d_req=1: latch D payload -> BUSY_D.
//   - d_lock=0 and d_req=0: -> IDLE.
// - Latency: request visible in IDLE -> m_req the next cycle -> ack in the m_ack cycle.
//   Minimum is 2 cycles per transaction for a zero-wait bus (m_ack the cycle after m_req rises).
//   Every transaction passes through IDLE, except D->D under lock.
// - m_ack outside BUSY_x: ignored.
// - Reset mid-transaction: drops m_req immediately. The bus slave shares the same reset.
// CONFIGURATION
// - MEM_ARB_TIMEOUT_EN defined:
//   - Counter clears on entry to BUSY_x and counts each cycle without m_ack.
//   - At TIMEOUT_CYCLES-1 with no m_ack: x_ack=1, x_rdata=0, bus_err=1, m_req=0, next state IDLE.
//   - A lock is broken by the timeout.
// - MEM_ARB_TIMEOUT_EN undefined: no counter, bus_err tied 0, BUSY_x waits indefinitely.
// STRUCTURE
// - Package mem_arb_pkg: arb_state_t enum {IDLE, BUSY_I, BUSY_D, LOCK_HOLD};
//   arb_port_t enum {PORT_I, PORT_D}; constant BE_ALL.
// - Sub-module mem_arb_watchdog (timeout counter), instantiated only under MEM_ARB_TIMEOUT_EN.
// - Grant/starve logic and FSM stay in the top.
// TESTING
// - Single fetch: i_req, i_addr=0x100, m_ack 1 cycle after m_req, m_rdata=0x13
//   -> m_addr=0x100, m_we=0, i_ack=1, i_rdata=0x13.
// - Simultaneous request: i_req and d_req (d_we=1, d_addr=0x2000, d_wdata=0xDEADBEEF, d_be=4'b0011) in IDLE
//   -> D served first with that payload; I served next.
// - Starvation: d_req and i_req held continuously, STARVE_LIMIT=4
//   -> grant order D,D,D,D,I,D..., with starve_cnt back to 0 after I.
// - Atomic: d_lock=1 on AMO read at 0x3000, then write, i_req high throughout
//   -> no I grant until the write is acked with d_lock=0.
// - Reset: reset pulse while in BUSY_D -> next cycle IDLE, m_req=0, no ack emitted.
// - Timeout (MEM_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=8): m_ack never asserted
//   -> 8 cycles after m_req rises: d_ack=1, d_rdata=0, bus_err=1, then IDLE.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Purpose: shared types and constants for the I/D memory port arbiter.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
package mem_arb_pkg;

  // Arbiter FSM states.
  typedef enum logic [1:0] {
    IDLE,
    BUSY_I,
    BUSY_D,
    LOCK_HOLD
  } arb_state_t;

  // Port selected by the IDLE arbitration.
  typedef enum logic {
    PORT_I,
    PORT_D
  } arb_port_t;

  // Wide all-ones byte-enable source; users take the low DATA_W/8 bits.
  localparam int unsigned BE_W_MAX = 128;
  localparam logic [BE_W_MAX-1:0] BE_ALL = '1;

  // The starve counter holds STARVE_LIMIT, which ranges over 1..15.
  localparam int unsigned STARVE_W = 4;

endpackage

// File: rtl/mem_arb_watchdog.sv
// Purpose: bus-transaction watchdog; flags a transaction that has gone TIMEOUT_CYCLES cycles without m_ack.
// Latency: expired is combinational in the TIMEOUT_CYCLES-th busy cycle (the counter reads 0 in the first busy cycle).
// Backpressure: none; the arbiter aborts the transaction when expired is high.
// Ports: clk, reset (sync, active-high), busy (arbiter in BUSY_x), m_ack (bus completion), expired (abort pulse).
module mem_arb_watchdog #(
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic clk,
  input  logic reset,
  input  logic busy,
  input  logic m_ack,
  output logic expired
);

  localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] cnt;

  assign expired = busy && !m_ack && (cnt == CNT_LAST);

  // Every transaction enters BUSY_x from a non-busy state.
  // Holding the counter at zero outside BUSY_x therefore clears it on entry.
  always_ff @(posedge clk) begin
    if (reset || !busy || m_ack || expired) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Purpose: shares one memory bus port between fetch (I) and data/atomic (D); D keeps the bus across d_lock sequences.
// Latency: request seen in IDLE -> m_req next cycle -> x_ack combinational in the m_ack cycle (2 cycles minimum).
// Backpressure: requesters hold x_req/payload until x_ack; stall_if/stall_mem report the wait. m_req is held until m_ack.
// Ports: clk, reset (sync, active-high)
//        I side:  i_req, i_addr -> i_ack, i_rdata
//        D side:  d_req, d_we, d_addr, d_wdata, d_be, d_lock -> d_ack, d_rdata
//        bus:     m_req, m_we, m_addr, m_wdata, m_be (registered) <- m_ack, m_rdata
//        status:  stall_if, stall_mem, bus_err
// Option: define MEM_ARB_TIMEOUT_EN to add the watchdog.
//         Without it, bus_err is tied 0 and BUSY_x waits indefinitely.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W         = 32,
  parameter int unsigned DATA_W         = 32,
  parameter int unsigned STARVE_LIMIT   = 4,
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                i_req,
  input  logic [ADDR_W-1:0]   i_addr,
  output logic                i_ack,
  output logic [DATA_W-1:0]   i_rdata,
  input  logic                d_req,
  input  logic                d_we,
  input  logic [ADDR_W-1:0]   d_addr,
  input  logic [DATA_W-1:0]   d_wdata,
  input  logic [DATA_W/8-1:0] d_be,
  input  logic                d_lock,
  output logic                d_ack,
  output logic [DATA_W-1:0]   d_rdata,
  output logic                m_req,
  output logic                m_we,
  output logic [ADDR_W-1:0]   m_addr,
  output logic [DATA_W-1:0]   m_wdata,
  output logic [DATA_W/8-1:0] m_be,
  input  logic                m_ack,
  input  logic [DATA_W-1:0]   m_rdata,
  output logic                stall_if,
  output logic                stall_mem,
  output logic                bus_err
);

  localparam int unsigned BE_W = DATA_W / 8;
  localparam logic [STARVE_W-1:0] STARVE_MAX = STARVE_W'(STARVE_LIMIT);

  arb_state_t          state;
  logic [STARVE_W-1:0] starve_cnt;
  arb_port_t           idle_pick;
  logic                in_idle, in_lock, busy_i, busy_d;
  logic                grant_i, grant_d, xfer_done, timeout;

  assign in_idle = (state == IDLE);
  assign in_lock = (state == LOCK_HOLD);
  assign busy_i  = (state == BUSY_I);
  assign busy_d  = (state == BUSY_D);

`ifdef MEM_ARB_TIMEOUT_EN
  mem_arb_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk     (clk),
    .reset   (reset),
    .busy    (busy_i || busy_d),
    .m_ack   (m_ack),
    .expired (timeout)
  );
`else
  assign timeout = 1'b0;
`endif

  // Completion is the bus ack or a watchdog abort. The watchdog only fires without m_ack.
  // So read data is m_rdata on a real ack and zero on an abort.
  assign xfer_done = (busy_i || busy_d) && (m_ack || timeout);

  assign i_ack     = busy_i && (m_ack || timeout);
  assign d_ack     = busy_d && (m_ack || timeout);
  assign i_rdata   = (busy_i && m_ack) ? m_rdata : '0;
  assign d_rdata   = (busy_d && m_ack) ? m_rdata : '0;
  assign bus_err   = timeout;
  assign stall_if  = i_req && !i_ack;
  assign stall_mem = d_req && !d_ack;

  // IDLE arbitration: D has priority.
  // I wins once D has taken STARVE_LIMIT grants back to back while I waited.
  always_comb begin
    idle_pick = PORT_D;
    if (i_req && (!d_req || starve_cnt == STARVE_MAX)) begin
      idle_pick = PORT_I;
    end
  end

  // LOCK_HOLD grants only D, whatever the starve count says.
  assign grant_i = in_idle && i_req && (idle_pick == PORT_I);
  assign grant_d = (in_idle && d_req && (idle_pick == PORT_D)) || (in_lock && d_req);

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      starve_cnt <= '0;
      m_req      <= 1'b0;
      m_we       <= 1'b0;
      m_addr     <= '0;
      m_wdata    <= '0;
      m_be       <= '0;
    end else begin
      if (grant_i) begin
        state      <= BUSY_I;
        starve_cnt <= '0;
        m_req      <= 1'b1;
        m_we       <= 1'b0;
        m_addr     <= i_addr;
        m_wdata    <= '0;
        m_be       <= BE_ALL[BE_W-1:0];
      end else if (grant_d) begin
        state   <= BUSY_D;
        m_req   <= 1'b1;
        m_we    <= d_we;
        m_addr  <= d_addr;
        m_wdata <= d_wdata;
        m_be    <= d_be;
        // Locked D->D grants can run past the limit; saturate so the count stays meaningful.
        if (i_req && starve_cnt != STARVE_MAX) begin
          starve_cnt <= starve_cnt + 1'b1;
        end
      end else if (xfer_done) begin
        m_req <= 1'b0;
        // A timeout abort always releases the lock.
        if (busy_d && d_lock && !timeout) begin
          state <= LOCK_HOLD;
        end else begin
          state <= IDLE;
        end
      end else if (in_lock && !d_lock) begin
        state <= IDLE;
      end
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Purpose: self-checking bench for mem_port_arbiter (directed scenarios plus randomized traffic against a reference model).
// Latency: samples registered outputs 1ns after the rising edge; drives inputs then; samples acks 1ns later.
// Backpressure: bench requesters hold payload until ack; the bench bus model acks after random waits.
module tb_mem_port_arbiter;

  localparam int unsigned AW      = 32;
  localparam int unsigned DW      = 32;
  localparam int unsigned STARVE  = 4;
  localparam int unsigned TIMEOUT = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic          i_req;
  logic [AW-1:0] i_addr;
  logic          i_ack;
  logic [DW-1:0] i_rdata;
  logic          d_req, d_we, d_lock;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata;
  logic [3:0]    d_be;
  logic          d_ack;
  logic [DW-1:0] d_rdata;
  logic          m_req, m_we;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata;
  logic [3:0]    m_be;
  logic          m_ack;
  logic [DW-1:0] m_rdata;
  logic          stall_if, stall_mem, bus_err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(
    .ADDR_W(AW), .DATA_W(DW), .STARVE_LIMIT(STARVE), .TIMEOUT_CYCLES(TIMEOUT)
  ) dut (
    .clk(clk), .reset(reset),
    .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack), .i_rdata(i_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_be(d_be),
    .d_lock(d_lock), .d_ack(d_ack), .d_rdata(d_rdata),
    .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata), .m_be(m_be),
    .m_ack(m_ack), .m_rdata(m_rdata),
    .stall_if(stall_if), .stall_mem(stall_mem), .bus_err(bus_err)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; i_req = 0; i_addr = '0; d_req = 0; d_we = 0; d_addr = '0;
    d_wdata = '0; d_be = '0; d_lock = 0; m_ack = 0; m_rdata = '0;
    tick(); tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; i_req = 1; i_addr = 32'h44; d_req = 1; d_addr = 32'h88;
    m_ack = 0; d_lock = 0;
    tick(); tick();
    checks++; if (m_req !== 1'b0) begin errors++; $display("FAIL reset_m_req got %b exp 0", m_req); end
    checks++; if (m_addr !== 32'h0) begin errors++; $display("FAIL reset_m_addr got %h exp 0", m_addr); end
    checks++; if ({m_we, m_be} !== 5'b0) begin errors++; $display("FAIL reset_m_we_be got %b exp 0", {m_we, m_be}); end
    checks++; if (m_wdata !== 32'h0) begin errors++; $display("FAIL reset_m_wdata got %h exp 0", m_wdata); end
    checks++; if ({i_ack, d_ack, bus_err} !== 3'b0) begin errors++; $display("FAIL reset_acks got %b exp 000", {i_ack, d_ack, bus_err}); end
    do_reset();
  endtask

  task automatic test_single_fetch();
    do_reset();
    i_req = 1; i_addr = 32'h100;
    checks++; #1; if (stall_if !== 1'b1) begin errors++; $display("FAIL fetch_stall_idle got %b exp 1", stall_if); end
    tick();
    checks++; if (m_req !== 1'b1) begin errors++; $display("FAIL fetch_m_req got %b exp 1", m_req); end
    checks++; if (m_addr !== 32'h100) begin errors++; $display("FAIL fetch_m_addr got %h exp 100", m_addr); end
    checks++; if ({m_we, m_be} !== 5'b0_1111) begin errors++; $display("FAIL fetch_we_be got %b exp 01111", {m_we, m_be}); end
    m_ack = 1; m_rdata = 32'h13;
    #1;
    checks++; if (i_ack !== 1'b1) begin errors++; $display("FAIL fetch_i_ack got %b exp 1", i_ack); end
    checks++; if (i_rdata !== 32'h13) begin errors++; $display("FAIL fetch_i_rdata got %h exp 13", i_rdata); end
    checks++; if ({d_ack, d_rdata} !== 33'h0) begin errors++; $display("FAIL fetch_d_quiet got %h exp 0", {d_ack, d_rdata}); end
    checks++; if (stall_if !== 1'b0) begin errors++; $display("FAIL fetch_stall_ack got %b exp 0", stall_if); end
    tick();
    i_req = 0; m_ack = 0;
    checks++; if (m_req !== 1'b0) begin errors++; $display("FAIL fetch_m_req_drop got %b exp 0", m_req); end
  endtask

  task automatic test_simultaneous();
    do_reset();
    i_req = 1; i_addr = 32'h400;
    d_req = 1; d_we = 1; d_addr = 32'h2000; d_wdata = 32'hDEADBEEF; d_be = 4'b0011;
    tick();
    checks++; if ({m_req, m_we, m_addr} !== {2'b11, 32'h2000}) begin errors++; $display("FAIL simul_d_first got req/we/addr %b%b %h exp 11 2000", m_req, m_we, m_addr); end
    checks++; if ({m_wdata, m_be} !== {32'hDEADBEEF, 4'b0011}) begin errors++; $display("FAIL simul_d_payload got %h %b exp deadbeef 0011", m_wdata, m_be); end
    m_ack = 1; m_rdata = 32'h77;
    #1;
    checks++; if ({d_ack, i_ack} !== 2'b10) begin errors++; $display("FAIL simul_d_ack got d/i %b exp 10", {d_ack, i_ack}); end
    checks++; if (i_rdata !== 32'h0) begin errors++; $display("FAIL simul_i_rdata_quiet got %h exp 0", i_rdata); end
    tick();
    d_req = 0; m_ack = 0;
    checks++; if (m_req !== 1'b0) begin errors++; $display("FAIL simul_idle got %b exp 0", m_req); end
    tick();
    checks++; if ({m_req, m_we, m_addr} !== {2'b10, 32'h400}) begin errors++; $display("FAIL simul_i_next got %b%b %h exp 10 400", m_req, m_we, m_addr); end
    m_ack = 1; m_rdata = 32'h99;
    #1;
    checks++; if ({i_ack, i_rdata} !== {1'b1, 32'h99}) begin errors++; $display("FAIL simul_i_ack got %b %h exp 1 99", i_ack, i_rdata); end
    tick();
    i_req = 0; m_ack = 0;
  endtask

  task automatic test_starvation();
    int       got[$];
    int       owner;
    logic [DW-1:0] rd;
    do_reset();
    i_req = 1; i_addr = 32'hA0;
    d_req = 1; d_we = 1; d_addr = 32'hB0; d_wdata = 32'h1; d_be = 4'hF;
    for (int c = 0; c < 60 && got.size() < 10; c++) begin
      tick();
      if (m_req) begin
        owner = (m_addr == 32'hA0) ? 0 : 1;
        got.push_back(owner);
        rd = $urandom; m_ack = 1; m_rdata = rd;
        #1;
        checks++;
        if ({i_ack, d_ack} !== ((owner == 0) ? 2'b10 : 2'b01)) begin
          errors++; $display("FAIL starve_ack_route got i/d %b owner %0d", {i_ack, d_ack}, owner);
        end
      end else begin
        m_ack = 0;
      end
    end
    tick();
    i_req = 0; d_req = 0; m_ack = 0;
    checks++;
    if (got.size() != 10) begin
      errors++; $display("FAIL starve_count got %0d grants exp 10", got.size());
    end else begin
      // D four times, then I, repeating: the counter restarts from zero after each I grant.
      for (int k = 0; k < 10; k++) begin
        checks++;
        if (got[k] != ((k % 5 == 4) ? 0 : 1)) begin
          errors++; $display("FAIL starve_order grant %0d got port %0d exp %0d", k, got[k], (k % 5 == 4) ? 0 : 1);
        end
      end
    end
    tick();
  endtask

  task automatic test_atomic();
    do_reset();
    i_req = 1; i_addr = 32'h500;
    d_req = 1; d_lock = 1; d_we = 0; d_addr = 32'h3000; d_be = 4'hF;
    tick();
    checks++; if ({m_req, m_we, m_addr} !== {2'b10, 32'h3000}) begin errors++; $display("FAIL amo_read_grant got %b%b %h exp 10 3000", m_req, m_we, m_addr); end
    m_ack = 1; m_rdata = 32'h55;
    #1;
    checks++; if ({d_ack, d_rdata, i_ack} !== {1'b1, 32'h55, 1'b0}) begin errors++; $display("FAIL amo_read_ack got %b %h %b exp 1 55 0", d_ack, d_rdata, i_ack); end
    tick();
    m_ack = 0; d_req = 0;
    for (int k = 0; k < 6; k++) begin
      checks++;
      if ({m_req, i_ack} !== 2'b00) begin errors++; $display("FAIL amo_hold cycle %0d got req/iack %b exp 00", k, {m_req, i_ack}); end
      tick();
    end
    d_req = 1; d_we = 1; d_wdata = 32'h56;
    tick();
    d_lock = 0;
    checks++; if ({m_req, m_we, m_addr, m_wdata} !== {2'b11, 32'h3000, 32'h56}) begin errors++; $display("FAIL amo_write_grant got %b%b %h %h exp 11 3000 56", m_req, m_we, m_addr, m_wdata); end
    tick();
    checks++; if ({m_req, m_addr} !== {1'b1, 32'h3000}) begin errors++; $display("FAIL amo_write_stable got %b %h exp 1 3000", m_req, m_addr); end
    m_ack = 1;
    #1;
    checks++; if ({d_ack, i_ack} !== 2'b10) begin errors++; $display("FAIL amo_write_ack got d/i %b exp 10", {d_ack, i_ack}); end
    tick();
    d_req = 0; m_ack = 0;
    checks++; if (m_req !== 1'b0) begin errors++; $display("FAIL amo_release_idle got %b exp 0", m_req); end
    tick();
    checks++; if ({m_req, m_addr} !== {1'b1, 32'h500}) begin errors++; $display("FAIL amo_i_after got %b %h exp 1 500", m_req, m_addr); end
    m_ack = 1;
    tick();
    i_req = 0; m_ack = 0;
  endtask

  task automatic test_reset_mid();
    do_reset();
    d_req = 1; d_we = 0; d_addr = 32'h40; d_be = 4'hF; d_lock = 0;
    tick();
    checks++; if (m_req !== 1'b1) begin errors++; $display("FAIL rstmid_busy got %b exp 1", m_req); end
    reset = 1; d_req = 0;
    tick();
    reset = 0;
    checks++; if ({m_req, m_addr} !== {1'b0, 32'h0}) begin errors++; $display("FAIL rstmid_cleared got %b %h exp 0 0", m_req, m_addr); end
    m_ack = 1; m_rdata = 32'hFFFF;
    #1;
    checks++; if ({d_ack, i_ack, d_rdata} !== 34'h0) begin errors++; $display("FAIL rstmid_no_ack got %h exp 0", {d_ack, i_ack, d_rdata}); end
    tick();
    m_ack = 0;
    checks++; if (m_req !== 1'b0) begin errors++; $display("FAIL rstmid_stays_idle got %b exp 0", m_req); end
  endtask

`ifdef MEM_ARB_TIMEOUT_EN
  task automatic test_timeout();
    do_reset();
    d_req = 1; d_we = 0; d_addr = 32'h60; d_be = 4'hF; d_lock = 1;
    tick();
    checks++; if (m_req !== 1'b1) begin errors++; $display("FAIL tmo_start got %b exp 1", m_req); end
    for (int k = 0; k < int'(TIMEOUT) - 1; k++) begin
      checks++; if ({d_ack, bus_err} !== 2'b00) begin errors++; $display("FAIL tmo_early cycle %0d got %b exp 00", k, {d_ack, bus_err}); end
      tick();
    end
    #1;
    checks++; if ({d_ack, bus_err, d_rdata} !== {2'b11, 32'h0}) begin errors++; $display("FAIL tmo_fire got %b %b %h exp 1 1 0", d_ack, bus_err, d_rdata); end
    tick();
    d_req = 0;
    checks++; if (m_req !== 1'b0) begin errors++; $display("FAIL tmo_idle got %b exp 0", m_req); end
    d_lock = 0;
    tick();
  endtask
`endif

  // Randomized traffic. The reference model tracks whether a bus transaction is open and who owns it.
  // Ownership follows the arbitration rules: D first, I after STARVE consecutive D grants with I waiting.
  task automatic test_random();
    int            busy, owner, starve, dly, i_age, d_age;
    logic          p_i, p_d, p_ack, p_iack, p_dack, exp_i, exp_d;
    logic [DW-1:0] rd;
    busy = 0; owner = 0; starve = 0; dly = 0; i_age = 0; d_age = 0;
    p_i = 0; p_d = 0; p_ack = 0; p_iack = 0; p_dack = 0;
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      tick();
      if (busy != 0) begin
        if (p_ack) busy = 0;
      end else if (p_i || p_d) begin
        busy = 1;
        dly = $urandom_range(0, 3);
        if (p_i && (!p_d || starve == int'(STARVE))) begin
          owner = 0; starve = 0;
        end else begin
          owner = 1;
          if (p_i) starve = starve + 1;
        end
      end
      checks++;
      if (m_req !== (busy != 0)) begin errors++; $display("FAIL rnd_m_req cycle %0d got %b exp %0d", c, m_req, busy); end
      if (busy != 0) begin
        checks++;
        if (owner == 0) begin
          if ({m_we, m_addr, m_be} !== {1'b0, i_addr, 4'hF}) begin
            errors++; $display("FAIL rnd_i_payload cycle %0d got %b %h %b exp 0 %h 1111", c, m_we, m_addr, m_be, i_addr);
          end
        end else begin
          if ({m_we, m_addr, m_wdata, m_be} !== {d_we, d_addr, d_wdata, d_be}) begin
            errors++; $display("FAIL rnd_d_payload cycle %0d got %b %h %h %b exp %b %h %h %b", c, m_we, m_addr, m_wdata, m_be, d_we, d_addr, d_wdata, d_be);
          end
        end
      end
      // Requesters: drop after ack, then maybe raise a fresh request with a new payload.
      if (p_iack) i_req = 0;
      if (p_dack) d_req = 0;
      if (!i_req && ($urandom_range(0, 2) == 0)) begin
        i_req = 1; i_addr = $urandom; i_age = 0;
      end
      if (!d_req && ($urandom_range(0, 2) == 0)) begin
        d_req = 1; d_we = $urandom_range(0, 1); d_addr = $urandom;
        d_wdata = $urandom; d_be = 4'($urandom_range(0, 15)); d_age = 0;
      end
      // Bus: ack after a random wait; occasionally a stray ack while idle.
      rd = $urandom; m_rdata = rd;
      if (busy != 0) begin
        if (dly == 0) m_ack = 1;
        else begin m_ack = 0; dly = dly - 1; end
      end else begin
        m_ack = ($urandom_range(0, 7) == 0);
      end
      #1;
      exp_i = (busy != 0) && (owner == 0) && m_ack;
      exp_d = (busy != 0) && (owner == 1) && m_ack;
      checks++;
      if ({i_ack, i_rdata} !== {exp_i, exp_i ? rd : 32'h0}) begin errors++; $display("FAIL rnd_i_ack cycle %0d got %b %h exp %b", c, i_ack, i_rdata, exp_i); end
      checks++;
      if ({d_ack, d_rdata} !== {exp_d, exp_d ? rd : 32'h0}) begin errors++; $display("FAIL rnd_d_ack cycle %0d got %b %h exp %b", c, d_ack, d_rdata, exp_d); end
      checks++;
      if ({stall_if, stall_mem, bus_err} !== {i_req & ~exp_i, d_req & ~exp_d, 1'b0}) begin
        errors++; $display("FAIL rnd_stall cycle %0d got %b", c, {stall_if, stall_mem, bus_err});
      end
      i_age = i_req ? i_age + 1 : 0;
      d_age = d_req ? d_age + 1 : 0;
      checks++;
      if (i_age > 60 || d_age > 60) begin
        errors++; $display("FAIL rnd_progress cycle %0d ages i %0d d %0d limit 60", c, i_age, d_age);
        break;
      end
      p_i = i_req; p_d = d_req; p_ack = (busy != 0) && m_ack; p_iack = exp_i; p_dack = exp_d;
    end
    tick();
    i_req = 0; d_req = 0; m_ack = 0;
  endtask

  initial begin
    test_reset();
    test_single_fetch();
    test_simultaneous();
    test_starvation();
    test_atomic();
    test_reset_mid();
`ifdef MEM_ARB_TIMEOUT_EN
    test_timeout();
`endif
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation exceeded 500000 ns");
    $fatal(1, "bench time limit reached");
  end

endmodule
